// File: rtl/render_pkg.sv
// Shared rendering-pipeline types: default stream geometry and the triangle record
// handed from the unpacker to the rasterization stage.
package render_pkg;

  localparam int unsigned DEF_DATA_W        = 32;
  localparam int unsigned DEF_WORDS_PER_REC = 3;
  localparam int unsigned TRI_REC_W         = 96;

  typedef logic [TRI_REC_W-1:0] tri_rec_t;

  typedef enum logic [0:0] {
    StEmpty,
    StFull
  } out_state_e;

endpackage

// File: rtl/triangle_unpack_if.sv
// Word-in / record-out stream bundle for triangle_unpack; the slave modport is the
// unpacker itself, the master modport is the surrounding page logic.
interface triangle_unpack_if #(
  parameter int unsigned DATA_W        = 32,
  parameter int unsigned WORDS_PER_REC = 3
);
  localparam int unsigned REC_W = DATA_W * WORDS_PER_REC;

  logic [DATA_W-1:0] in_tdata;
  logic              in_tvalid;
  logic              in_tready;
  logic [REC_W-1:0]  out_tdata;
  logic              out_tvalid;
  logic              out_tready;

  modport master (
    output in_tdata, in_tvalid, out_tready,
    input  in_tready, out_tdata, out_tvalid
  );

  modport slave (
    input  in_tdata, in_tvalid, out_tready,
    output in_tready, out_tdata, out_tvalid
  );
endinterface

// File: rtl/triangle_unpack_tri_out_reg.sv
// tri_out_reg: single-entry EMPTY/FULL holding register for assembled records; also
// produces the input stall term (last word arriving while a record is stuck).
module tri_out_reg import render_pkg::*; #(
  parameter int unsigned REC_W = TRI_REC_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [REC_W-1:0] load_data,
  input  logic             is_last,
  input  logic             out_tready,
  output logic [REC_W-1:0] out_tdata,
  output logic             out_tvalid,
  output logic             stall
);

  out_state_e       state_q, state_d;
  logic [REC_W-1:0] data_q;

  // A load while FULL only happens alongside a transfer, because stall blocks it otherwise.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StEmpty: if (load) state_d = StFull;
      StFull:  if (out_tready && !load) state_d = StEmpty;
      default: state_d = StEmpty;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StEmpty;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (load) data_q <= load_data;
    end
  end

  assign out_tvalid = (state_q == StFull);
  assign out_tdata  = data_q;
  assign stall      = is_last && out_tvalid && !out_tready;

endmodule

// File: rtl/triangle_unpack.sv
// Packs WORDS_PER_REC consecutive input words into one registered record.
// Optional record counter enabled with `define TRI_UNPACK_CNT_EN.
module triangle_unpack import render_pkg::*; #(
  parameter int unsigned DATA_W        = DEF_DATA_W,
  parameter int unsigned WORDS_PER_REC = DEF_WORDS_PER_REC,
  parameter int unsigned CNT_W         = 16
) (
  input logic clk,
  input logic reset,
  triangle_unpack_if.slave bus
`ifdef TRI_UNPACK_CNT_EN
  ,
  output logic [CNT_W-1:0] rec_count
`endif
);

  localparam int unsigned REC_W = DATA_W * WORDS_PER_REC;
  localparam int unsigned IDX_W = $clog2(WORDS_PER_REC);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS_PER_REC - 1);

  if (WORDS_PER_REC < 2 || WORDS_PER_REC > 8) begin : g_bad_words_per_rec
    $error("WORDS_PER_REC must be within 2..8");
  end

  logic [IDX_W-1:0]  idx_q, idx_d;
  logic              is_last;
  logic              stall;
  logic              word_acc;
  logic [DATA_W-1:0] slot_q [WORDS_PER_REC-1];
  logic [REC_W-1:0]  rec;

  assign is_last       = (idx_q == LAST_IDX);
  assign bus.in_tready = !stall;
  assign word_acc      = bus.in_tvalid && !stall;

  always_comb begin
    idx_d = idx_q;
    if (word_acc) idx_d = is_last ? '0 : idx_q + IDX_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) idx_q <= '0;
    else       idx_q <= idx_d;
  end

  // Slots are never read before being written, so they carry no reset.
  always_ff @(posedge clk) begin
    for (int k = 0; k < WORDS_PER_REC - 1; k++) begin
      if (word_acc && idx_q == IDX_W'(k)) slot_q[k] <= bus.in_tdata;
    end
  end

  // The last word bypasses the slots and goes straight into the output register.
  always_comb begin
    rec = '0;
    for (int k = 0; k < WORDS_PER_REC - 1; k++) begin
      rec[k*DATA_W +: DATA_W] = slot_q[k];
    end
    rec[REC_W-1 -: DATA_W] = bus.in_tdata;
  end

  tri_out_reg #(
    .REC_W(REC_W)
  ) u_out_reg (
    .clk       (clk),
    .reset     (reset),
    .load      (word_acc && is_last),
    .load_data (rec),
    .is_last   (is_last),
    .out_tready(bus.out_tready),
    .out_tdata (bus.out_tdata),
    .out_tvalid(bus.out_tvalid),
    .stall     (stall)
  );

`ifdef TRI_UNPACK_CNT_EN
  logic [CNT_W-1:0] rec_count_q;

  always_ff @(posedge clk) begin
    if (reset) rec_count_q <= '0;
    else if (bus.out_tvalid && bus.out_tready) rec_count_q <= rec_count_q + CNT_W'(1);
  end

  assign rec_count = rec_count_q;
`else
  logic [CNT_W-1:0] unused_cnt_w;
  assign unused_cnt_w = '0;
`endif

endmodule

// File: doc/triangle_unpack.md
# triangle_unpack

Stream unpacker between the `data_redir_m` kernel output and the rasterization stage of the rendering pipeline. It takes the 32-bit word stream that `data_redir_m` produces and assembles every `WORDS_PER_REC` consecutive words into one wide triangle record. Each record is presented on a registered valid/ready output, and the block sustains one input word per cycle. It sits inside a page alongside `leaf_interface`, on the user side, and adds no BFT-side logic.

## Interface
Parameters:
- `DATA_W`, 32, width of each input word.
- `WORDS_PER_REC`, 3, words per record; legal range 2..8.
- `CNT_W`, 16, record counter width; used only with `TRI_UNPACK_CNT_EN`.

Ports:
- `clk` in 1: single clock.
- `reset` in 1: reset is synchronous and active-high.
- `in_tdata` in `DATA_W`: input word.
- `in_tvalid` in 1: input word valid.
- `in_tready` out 1: block accepts the word this cycle.
- `out_tdata` out `DATA_W*WORDS_PER_REC`: assembled record; word k sits at bits `[k*DATA_W +: DATA_W]`.
- `out_tvalid` out 1: record valid.
- `out_tready` in 1: downstream accepts the record.
- `rec_count` out `CNT_W`: records delivered. Present only with `TRI_UNPACK_CNT_EN`.

## Operation
- A word transfers when `in_tvalid && in_tready`.
- A record transfers when `out_tvalid && out_tready`.
- Word index counter `idx` runs 0..`WORDS_PER_REC-1`.
  - Each accepted word is written into assembly slot `idx`, then `idx` increments.
  - After the last slot, `idx` wraps to 0.
- On acceptance of the word with `idx == WORDS_PER_REC-1`, the full record (assembly slots plus the current word) loads into the output register and `out_tvalid` is set.
- Output register states: EMPTY (`out_tvalid`=0) and FULL (`out_tvalid`=1).
  - EMPTY -> FULL on last-word acceptance.
  - FULL -> EMPTY on record transfer with no simultaneous last-word acceptance.
  - FULL -> FULL (reload) when a record transfers and a last word is accepted in the same cycle.
- `in_tready` = `!(idx == WORDS_PER_REC-1 && out_tvalid && !out_tready)`.
  - Non-last words are always accepted, so the block buffers one record plus one partial record.
  - `in_tready` depends combinationally on `out_tready`. This is the only combinational path in the block.
- `out_tdata` is held stable while `out_tvalid && !out_tready`.
- Assembly slots need no reset. Unfilled slots never reach the output.

## Timing
- Reset values: `idx`=0, `out_tvalid`=0, `out_tdata`=0, `rec_count`=0. `in_tready` evaluates to 1 out of reset.
- Latency: `out_tvalid` rises the cycle after the last word of a record is accepted.
- Throughput: with `out_tready` held at 1 and `in_tvalid` held at 1, one record every `WORDS_PER_REC` cycles with no bubbles.
- Backpressure:
  - The block stalls only on a last word arriving while the output is FULL and not draining.
  - It resumes in the cycle `out_tready` rises, with a same-cycle hand-over.
- Reset mid-record: the partial record is discarded, `idx` returns to 0, and a held output record is dropped.
- `in_tvalid` may drop between words. The partial record waits indefinitely; there is no timeout.

## Configuration
- `TRI_UNPACK_CNT_EN` defined:
  - `rec_count` port exists and increments by 1 on each record transfer.
  - It wraps modulo 2^`CNT_W`.
  - It is cleared by `reset`.
- `TRI_UNPACK_CNT_EN` undefined: no counter, no `rec_count` port. Datapath behaviour is identical.

## Structure
- Shared package `render_pkg`:
  - default `DATA_W` and `WORDS_PER_REC` localparams
  - triangle record width constant `TRI_REC_W = 96`
  - typedef `tri_rec_t` for the 96-bit record, shared with the rasterization stage.
- One natural sub-module, `tri_out_reg`: the single-entry output holding register (FULL/EMPTY flag plus data). It also owns the `in_tready` stall term.
- Parameter check: elaboration fails if `WORDS_PER_REC` is outside 2..8.

## Test plan
- Stream words 0x11111111, 0x22222222, 0x33333333 with `out_tready`=1 -> one cycle after the third word, `out_tvalid`=1 and `out_tdata`=0x333333332222222211111111. Next cycle `out_tvalid`=0.
- 30 back-to-back words with `out_tready`=1 -> 10 records, `in_tready` never low; `rec_count`=10 with `TRI_UNPACK_CNT_EN`.
- Hold `out_tready`=0 after the first record and send 5 more words:
  - words 4 and 5 are accepted, and `in_tready`=0 with word 6 presented;
  - raise `out_tready` -> record 1 transfers and word 6 is accepted in the same cycle;
  - record 2 is valid the following cycle, and `out_tdata` stayed stable throughout the stall.
- Send 2 words, assert `reset` for 1 cycle, then send 0xA, 0xB, 0xC -> the single record output is 0x0000000C0000000B0000000A.
- Random `in_tvalid`/`out_tready` over 1000 records -> the scoreboard matches every record in order, with no loss and no duplication.
- `WORDS_PER_REC`=4 build, `CNT_W`=4 with `TRI_UNPACK_CNT_EN`, 17 records -> each record is 128 bits with the correct word order; `rec_count` wraps to 1.
